// File: rtl/lname_mbus_master_txarb_pkg.sv
// Shared definitions for the MBus master TX arbiter.
//   - default MBus address/data widths
//   - FSM state encoding
//   - cyclic index helper used by the round-robin arbiter
package lname_mbus_master_txarb_pkg;

  localparam int MBUS_ADDR_WIDTH = 32;
  localparam int MBUS_DATA_WIDTH = 32;

  typedef enum logic [2:0] {
    LNAME_MBUS_TXARB_ST_IDLE = 3'd0,
    LNAME_MBUS_TXARB_ST_WORD = 3'd1,
    LNAME_MBUS_TXARB_ST_ACKW = 3'd2,
    LNAME_MBUS_TXARB_ST_NEXT = 3'd3,
    LNAME_MBUS_TXARB_ST_RESP = 3'd4,
    LNAME_MBUS_TXARB_ST_RACK = 3'd5
  } txarb_state_e;

  // (base + step) modulo n, for walking channels cyclically.
  function automatic int cyc_next(input int base, input int step, input int n);
    return (base + step) % n;
  endfunction

endpackage

// File: rtl/lname_mbus_rr_arb.sv
// Combinational priority + round-robin arbiter.
//   req     : per-channel request
//   prio    : per-channel priority; any prioritised requester beats all others
//   pointer : last winner; the search starts at pointer+1 and wraps
//   grant   : one-hot winner
//   index   : encoded winner
//   valid   : at least one request present
module lname_mbus_rr_arb
  import lname_mbus_master_txarb_pkg::*;
#(
  parameter int NUM_CH      = 4,
  parameter int CH_ID_WIDTH = $clog2(NUM_CH)
) (
  input  logic [NUM_CH-1:0]      req,
  input  logic [NUM_CH-1:0]      prio,
  input  logic [CH_ID_WIDTH-1:0] pointer,
  output logic [NUM_CH-1:0]      grant,
  output logic [CH_ID_WIDTH-1:0] index,
  output logic                   valid
);

  logic [NUM_CH-1:0] hi_req;
  logic [NUM_CH-1:0] cand;

  assign hi_req = req & prio;
  assign cand   = (|hi_req) ? hi_req : req;
  assign valid  = |req;

  // Walk from the farthest position back toward pointer+1 so the last hit
  // (the nearest one after the pointer) is the one that sticks.
  always_comb begin
    int c;
    grant = '0;
    index = '0;
    c     = 0;
    for (int i = NUM_CH; i >= 1; i--) begin
      c = cyc_next(int'(pointer), i, NUM_CH);
      if (cand[c]) begin
        grant    = '0;
        grant[c] = 1'b1;
        index    = CH_ID_WIDTH'(c);
      end
    end
  end

endmodule

// File: rtl/lname_mbus_master_txarb.sv
// N-channel TX arbiter and handshake sequencer in front of the MBus master
// node TX port. One channel is granted per message (priority first, then
// round-robin); the grant is held across TX_PEND sequences and all
// handshakes to either side are registered four-phase.
//
// Ports:
//   CLK_EXT, RESETn                      clock, async active-low reset
//   CH_TX_ADDR/DATA/REQ/PEND/PRIORITY    per-channel request side
//   CH_TX_RESP_ACK                       per-channel response acknowledge
//   CH_TX_ACK/SUCC/FAIL                  per-channel status (registered)
//   TX_ADDR/DATA/REQ/PEND/PRIORITY       to node (registered)
//   TX_RESP_ACK                          to node (registered)
//   TX_ACK/SUCC/FAIL                     from node
//   TO_THRESHOLD, CLEAR_FLAG             response timeout limit / flag clear
//   GRANT_ID, BUSY, TIMEOUT_FLAG         status
//
// Build option: define LNAME_MBUS_TXARB_TIMEOUT_EN to enable the response
// timeout self-acknowledge; otherwise RESP waits indefinitely and
// TIMEOUT_FLAG is tied low.
module lname_mbus_master_txarb
  import lname_mbus_master_txarb_pkg::*;
#(
  parameter int NUM_CH      = 4,
  parameter int CH_ID_WIDTH = $clog2(NUM_CH),
  parameter int ADDR_WIDTH  = MBUS_ADDR_WIDTH,
  parameter int DATA_WIDTH  = MBUS_DATA_WIDTH,
  parameter int TO_WIDTH    = 16
) (
  input  logic                         CLK_EXT,
  input  logic                         RESETn,
  input  logic [NUM_CH*ADDR_WIDTH-1:0] CH_TX_ADDR,
  input  logic [NUM_CH*DATA_WIDTH-1:0] CH_TX_DATA,
  input  logic [NUM_CH-1:0]            CH_TX_REQ,
  input  logic [NUM_CH-1:0]            CH_TX_PEND,
  input  logic [NUM_CH-1:0]            CH_TX_PRIORITY,
  input  logic [NUM_CH-1:0]            CH_TX_RESP_ACK,
  output logic [NUM_CH-1:0]            CH_TX_ACK,
  output logic [NUM_CH-1:0]            CH_TX_SUCC,
  output logic [NUM_CH-1:0]            CH_TX_FAIL,
  output logic [ADDR_WIDTH-1:0]        TX_ADDR,
  output logic [DATA_WIDTH-1:0]        TX_DATA,
  output logic                         TX_REQ,
  output logic                         TX_PEND,
  output logic                         TX_PRIORITY,
  output logic                         TX_RESP_ACK,
  input  logic                         TX_ACK,
  input  logic                         TX_SUCC,
  input  logic                         TX_FAIL,
  input  logic [TO_WIDTH-1:0]          TO_THRESHOLD,
  input  logic                         CLEAR_FLAG,
  output logic [CH_ID_WIDTH-1:0]       GRANT_ID,
  output logic                         BUSY,
  output logic                         TIMEOUT_FLAG
);

  txarb_state_e state_q, state_d;

  logic [CH_ID_WIDTH-1:0] gnt_q, gnt_d, ptr_q, ptr_d, sel;
  logic [ADDR_WIDTH-1:0]  addr_q, addr_d;
  logic [DATA_WIDTH-1:0]  data_q, data_d;
  logic                   req_q, req_d, pend_q, pend_d, prio_q, prio_d;
  logic                   rack_q, rack_d, rgot_q, rgot_d;
  logic [NUM_CH-1:0]      ack_q, ack_d, succ_q, succ_d, fail_q, fail_d;

  logic [NUM_CH-1:0]      unused_arb_grant;
  logic [CH_ID_WIDTH-1:0] arb_idx;
  logic                   arb_valid;
  logic                   early_fail, to_due, to_fire;

  lname_mbus_rr_arb #(
    .NUM_CH      (NUM_CH),
    .CH_ID_WIDTH (CH_ID_WIDTH)
  ) u_arb (
    .req     (CH_TX_REQ),
    .prio    (CH_TX_PRIORITY),
    .pointer (ptr_q),
    .grant   (unused_arb_grant),
    .index   (arb_idx),
    .valid   (arb_valid)
  );

  // Capture source: the arbiter winner in IDLE, the held grant afterwards.
  assign sel = (state_q == LNAME_MBUS_TXARB_ST_IDLE) ? arb_idx : gnt_q;

  // A node failure before the response phase aborts the word in flight.
  assign early_fail = TX_FAIL && (state_q == LNAME_MBUS_TXARB_ST_WORD ||
                                  state_q == LNAME_MBUS_TXARB_ST_ACKW ||
                                  state_q == LNAME_MBUS_TXARB_ST_NEXT);

  always_comb begin
    state_d = state_q;
    gnt_d   = gnt_q;
    ptr_d   = ptr_q;
    addr_d  = addr_q;
    data_d  = data_q;
    req_d   = req_q;
    pend_d  = pend_q;
    prio_d  = prio_q;
    rack_d  = rack_q;
    rgot_d  = rgot_q;
    ack_d   = ack_q;
    succ_d  = succ_q;
    fail_d  = fail_q;
    to_fire = 1'b0;
    if (early_fail) begin
      req_d         = 1'b0;
      ack_d[gnt_q]  = 1'b0;
      fail_d[gnt_q] = 1'b1;
      rgot_d        = 1'b1;  // response already known, skip capture
      state_d       = LNAME_MBUS_TXARB_ST_RESP;
    end else begin
      unique case (state_q)
        LNAME_MBUS_TXARB_ST_IDLE: if (arb_valid) begin
          gnt_d   = arb_idx;
          addr_d  = CH_TX_ADDR[int'(sel)*ADDR_WIDTH +: ADDR_WIDTH];
          data_d  = CH_TX_DATA[int'(sel)*DATA_WIDTH +: DATA_WIDTH];
          pend_d  = CH_TX_PEND[sel];
          prio_d  = CH_TX_PRIORITY[sel];  // held for the whole message
          req_d   = 1'b1;
          rgot_d  = 1'b0;
          state_d = LNAME_MBUS_TXARB_ST_WORD;
        end
        LNAME_MBUS_TXARB_ST_WORD: if (TX_ACK) begin
          req_d        = 1'b0;
          ack_d[gnt_q] = 1'b1;
          state_d      = LNAME_MBUS_TXARB_ST_ACKW;
        end
        LNAME_MBUS_TXARB_ST_ACKW: if (!CH_TX_REQ[gnt_q] && !TX_ACK) begin
          ack_d[gnt_q] = 1'b0;
          state_d      = pend_q ? LNAME_MBUS_TXARB_ST_NEXT : LNAME_MBUS_TXARB_ST_RESP;
        end
        LNAME_MBUS_TXARB_ST_NEXT: if (CH_TX_REQ[gnt_q]) begin
          addr_d  = CH_TX_ADDR[int'(sel)*ADDR_WIDTH +: ADDR_WIDTH];
          data_d  = CH_TX_DATA[int'(sel)*DATA_WIDTH +: DATA_WIDTH];
          pend_d  = CH_TX_PEND[sel];
          req_d   = 1'b1;
          state_d = LNAME_MBUS_TXARB_ST_WORD;
        end
        LNAME_MBUS_TXARB_ST_RESP: begin
          if (!rgot_q) begin
            if (TX_SUCC || TX_FAIL) begin
              succ_d[gnt_q] = TX_SUCC;
              fail_d[gnt_q] = TX_FAIL;
              rgot_d        = 1'b1;
            end
          end else if ((CH_TX_RESP_ACK[gnt_q] || to_due) && !CH_TX_REQ[gnt_q]) begin
            // Requiring the channel request low keeps an aborted channel
            // from re-entering arbitration with a stale request.
            rack_d  = 1'b1;
            to_fire = to_due && !CH_TX_RESP_ACK[gnt_q];
            state_d = LNAME_MBUS_TXARB_ST_RACK;
          end
        end
        LNAME_MBUS_TXARB_ST_RACK: if (!TX_SUCC && !TX_FAIL) begin
          rack_d        = 1'b0;
          succ_d[gnt_q] = 1'b0;
          fail_d[gnt_q] = 1'b0;
          ptr_d         = gnt_q;  // fairness moves only on completion
          state_d       = LNAME_MBUS_TXARB_ST_IDLE;
        end
        default: state_d = LNAME_MBUS_TXARB_ST_IDLE;
      endcase
    end
  end

  always_ff @(posedge CLK_EXT or negedge RESETn) begin
    if (!RESETn) begin
      state_q <= LNAME_MBUS_TXARB_ST_IDLE;
      gnt_q   <= '0;
      ptr_q   <= CH_ID_WIDTH'(NUM_CH - 1);
      addr_q  <= '0;
      data_q  <= '0;
      req_q   <= 1'b0;
      pend_q  <= 1'b0;
      prio_q  <= 1'b0;
      rack_q  <= 1'b0;
      rgot_q  <= 1'b0;
      ack_q   <= '0;
      succ_q  <= '0;
      fail_q  <= '0;
    end else begin
      state_q <= state_d;
      gnt_q   <= gnt_d;
      ptr_q   <= ptr_d;
      addr_q  <= addr_d;
      data_q  <= data_d;
      req_q   <= req_d;
      pend_q  <= pend_d;
      prio_q  <= prio_d;
      rack_q  <= rack_d;
      rgot_q  <= rgot_d;
      ack_q   <= ack_d;
      succ_q  <= succ_d;
      fail_q  <= fail_d;
    end
  end

`ifdef LNAME_MBUS_TXARB_TIMEOUT_EN
  logic [TO_WIDTH-1:0] to_cnt_q;
  logic                to_flag_q;

  // >= rather than == so a channel still holding its request past the
  // threshold is acknowledged as soon as it lets go.
  assign to_due = (state_q == LNAME_MBUS_TXARB_ST_RESP) && rgot_q &&
                  (TO_THRESHOLD != '0) && (to_cnt_q >= TO_THRESHOLD);

  always_ff @(posedge CLK_EXT or negedge RESETn) begin
    if (!RESETn) begin
      to_cnt_q  <= '0;
      to_flag_q <= 1'b0;
    end else begin
      if (state_d != LNAME_MBUS_TXARB_ST_RESP)
        to_cnt_q <= '0;
      else if (state_q == LNAME_MBUS_TXARB_ST_RESP && rgot_q &&
               !CH_TX_RESP_ACK[gnt_q] && to_cnt_q != '1)
        to_cnt_q <= to_cnt_q + 1'b1;
      if (to_fire)
        to_flag_q <= 1'b1;
      else if (CLEAR_FLAG)
        to_flag_q <= 1'b0;
    end
  end

  assign TIMEOUT_FLAG = to_flag_q;
`else
  logic unused_cfg;
  assign to_due       = 1'b0;
  assign TIMEOUT_FLAG = 1'b0;
  assign unused_cfg   = ^{TO_THRESHOLD, CLEAR_FLAG, to_fire};
`endif

  assign CH_TX_ACK   = ack_q;
  assign CH_TX_SUCC  = succ_q;
  assign CH_TX_FAIL  = fail_q;
  assign TX_ADDR     = addr_q;
  assign TX_DATA     = data_q;
  assign TX_REQ      = req_q;
  assign TX_PEND     = pend_q;
  assign TX_PRIORITY = prio_q;
  assign TX_RESP_ACK = rack_q;
  assign GRANT_ID    = gnt_q;
  assign BUSY        = (state_q != LNAME_MBUS_TXARB_ST_IDLE);

endmodule
